// File: rtl/cpu_debug_unit_pkg.sv
// Shared definitions for the CPU debug unit: debug address width and the
// memory-scan FSM state encoding.
package cpu_debug_unit_pkg;

  localparam int DBU_AW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } dbu_state_t;

endpackage

// File: rtl/cpu_debug_unit_btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce, then a one-cycle
// pulse on each accepted press. Releases are debounced but produce no pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  // Bring the raw button into the clock domain.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // with = the second stage would copy the first in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the accepted level
  // for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Registered rising-edge detect on the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/cpu_debug_unit.sv
// Debug front end for the single-cycle CPU: step/run clock enable, memory
// browse via inc/dec buttons, and a frozen-CPU checksum scan of memory.
module cpu_debug_unit
  import cpu_debug_unit_pkg::*;
#(
  parameter int                DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [DBU_AW-1:0] SCAN_LAST       = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              btn_step,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              btn_scan,
  output logic [DBU_AW-1:0] debug_a,
  input  logic [31:0]       debug_d,
  output logic              cpu_en,
  output logic [DBU_AW-1:0] disp_addr,
  output logic [31:0]       disp_data,
  output logic [31:0]       checksum,
  output logic              scan_busy,
  output logic              scan_done
);

  logic step_p, inc_p, dec_p, scan_p;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk), .rst(rst), .btn(btn_step), .pulse(step_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .rst(rst), .btn(btn_inc), .pulse(inc_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk(clk), .rst(rst), .btn(btn_dec), .pulse(dec_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_scan (
    .clk(clk), .rst(rst), .btn(btn_scan), .pulse(scan_p));

  dbu_state_t        state, state_nxt;
  logic [DBU_AW-1:0] addr;
  logic [DBU_AW-1:0] scan_ptr;
  logic [31:0]       acc;
  logic              scan_last;

  assign scan_last = (scan_ptr == SCAN_LAST);

  // Scan FSM next-state decode.
  // NOTE: state_nxt gets its default before the case so that no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (scan_p) state_nxt = ST_SCAN;
      ST_SCAN: if (scan_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Scan FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Scan datapath: walk 0..SCAN_LAST accumulating words, publish at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ptr <= '0;
      acc      <= '0;
      checksum <= '0;
    end else if (state == ST_IDLE) begin
      if (scan_p) begin
        scan_ptr <= '0;
        acc      <= '0;
      end
    end else if (state == ST_SCAN) begin
      acc      <= acc + debug_d;
      scan_ptr <= scan_ptr + DBU_AW'(1);
      if (scan_last) checksum <= acc + debug_d;
    end
  end

  // CPU enable: follows run while idle, one-cycle burst per step pulse,
  // forced off whenever the scan owns the memory port. Step pulses are only
  // honoured when the FSM stays idle, so ones landing in a scan are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_en <= 1'b0;
    end else begin
      cpu_en <= (state_nxt == ST_IDLE) &&
                (run || (step_p && state == ST_IDLE));
    end
  end

  // Browse address: inc/dec with natural 8-bit wrap, frozen during a scan;
  // simultaneous inc and dec cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (state == ST_IDLE && (inc_p ^ dec_p)) begin
      addr <= inc_p ? addr + DBU_AW'(1) : addr - DBU_AW'(1);
    end
  end

  // Display word tracks the browse address while idle, held during a scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    disp_data <= '0;
    else if (state == ST_IDLE)  disp_data <= debug_d;
  end

  assign debug_a   = (state == ST_SCAN) ? scan_ptr : addr;
  assign disp_addr = addr;
  assign scan_busy = (state != ST_IDLE);
  assign scan_done = (state == ST_DONE);

endmodule
